ef_smsdac_chk: RTL and testbench
================================

EF_SMSDAC_CHK -- requirements
Module: ef_smsdac_chk

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from DAC d_in to the matching d_out_* codes; legal range 1..8.
REQ-002 SHALL have parameter WIN_LOG2, default 8: check window of 2^WIN_LOG2 qualified samples; legal range 4..12.
REQ-003 SHALL have parameter BOUND, default 64: maximum allowed |accumulated error| per window, in input LSBs.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_b, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1: sample qualifier; checking and accumulation only when high.
REQ-007 SHALL have port clr, input, 1: synchronous clear of accumulator, counters and sticky flags.
REQ-008 SHALL have port d_in, input, 8: unsigned data presented to the DAC, same cycle as the DAC's d_in.
REQ-009 SHALL have ports d_out_3, d_out_2, d_out_1, d_out_0, input, 2 each: 3-level element codes from the DAC.
REQ-010 SHALL have port v_rec, output, 8: reconstructed unsigned value.
REQ-011 SHALL have port err, output, 9: signed error, delayed d_in minus v_rec.
REQ-012 SHALL have port win_done, output, 1: one-cycle pulse at window end.
REQ-013 SHALL have port fail, output, 1: sticky window-bound violation.
REQ-014 SHALL have port bad_code, output, 1: sticky illegal-code flag.
REQ-015 SHALL have port fail_cnt, output, 8: count of failed windows, saturating at 255.

Function
REQ-016 SHALL decode each code as level = bit1 + bit0 (0..2), and reconstruct v = 64*L3 + 32*L2 + 16*L1 + 8*L0 (range 0..240).
REQ-017 SHALL delay d_in by exactly LAT cycles, shifting every cycle regardless of en, to form d_ref aligned with the codes.
REQ-018 SHALL register v_rec and err one cycle after the codes are sampled; err = d_ref - v, 9-bit two's complement.
REQ-019 SHALL ignore samples, i.e. no accumulation, counting or flag update, until LAT cycles after reset or clr have elapsed.
REQ-020 SHALL treat d_out_3 = 01 or 10 in a qualified sample as illegal, because the 8x element bits are driven identically: set bad_code and still accumulate err.
REQ-021 SHALL, for each qualified sample, add err to a signed accumulator of width 9+WIN_LOG2 bits, which cannot overflow, and increment a window counter.
REQ-022 SHALL, on the sample that completes 2^WIN_LOG2 samples, compare |acc including that sample| > BOUND, pulse win_done on the next cycle, set fail and increment fail_cnt if the bound is violated, then clear acc and the counter so the next sample starts a fresh window.
REQ-023 SHALL leave acc and the window counter unchanged while en is low, so windows span gaps.
REQ-024 SHALL let clr take priority over a coincident window end: no win_done, no fail update, and restart the priming of REQ-019.
REQ-025 SHALL hold fail_cnt at 255 on further failures.

Reset
REQ-026 SHALL, while rst_b is low at a clock edge, set v_rec=0, err=0, win_done=0, fail=0, bad_code=0, fail_cnt=0, acc=0, window and priming counters=0, and the delay line=0.
REQ-027 SHALL have reset asserted mid-window discard the partial window with no win_done.

Structure
REQ-028 SHALL take element weights (64/32/16/8), code width and level decode constants from shared package ef_smsdac_pkg.
REQ-029 SHALL implement the d_in delay as sub-module ef_smsdac_dly, parameterised by width and LAT, with synchronous active-low reset.

Verification
REQ-030 SHALL cover: d_in=0x80 held, codes 11/00/00/00 -> v_rec=128, err=0, no fail after a full window.
REQ-031 SHALL cover: d_in=0x07 held, all codes 00 -> err=+7 per sample, acc=1792 at window end -> fail=1, fail_cnt=1, one win_done pulse.
REQ-032 SHALL cover: d_out_3=01 for one qualified sample -> bad_code=1, remaining sticky until clr.
REQ-033 SHALL cover: en low for 10 cycles mid-window -> win_done delayed by exactly 10 cycles.
REQ-034 SHALL cover: clr on the window-end sample -> no win_done, fail unchanged at 0, first LAT samples afterward ignored.
REQ-035 SHALL cover: 256 consecutive failing windows -> fail_cnt=255, then reset -> all outputs 0.

Source files
------------

// File: rtl/ef_smsdac_pkg.sv
// Shared constants and code-decode helpers for the segmented-DAC output checker.
package ef_smsdac_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ERR_W  = 9;
  localparam int unsigned CODE_W = 2;

  // Element weights in input LSBs, MSB element first.
  localparam int unsigned WEIGHT_3 = 64;
  localparam int unsigned WEIGHT_2 = 32;
  localparam int unsigned WEIGHT_1 = 16;
  localparam int unsigned WEIGHT_0 = 8;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [1:0]        level_t;

  // 3-level element: the level is the number of bits that are set.
  function automatic level_t code_level(code_t c);
    return level_t'(c[1]) + level_t'(c[0]);
  endfunction

  // The 8x element bits are driven together, so a mixed code means a fault.
  function automatic logic code_split(code_t c);
    return c[1] ^ c[0];
  endfunction

  function automatic logic [DATA_W-1:0] recon(code_t c3, code_t c2, code_t c1, code_t c0);
    return DATA_W'(WEIGHT_3 * code_level(c3) + WEIGHT_2 * code_level(c2) +
                   WEIGHT_1 * code_level(c1) + WEIGHT_0 * code_level(c0));
  endfunction

endpackage

// File: rtl/ef_smsdac_dly.sv
// Fixed-latency delay line; aligns DAC input data with the element codes.
module ef_smsdac_dly #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [LAT];

  // Shift every cycle; reset flushes the pipe to zero.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[LAT-1];

endmodule

// File: rtl/ef_smsdac_chk.sv
// Segmented-DAC output checker: reconstructs the DAC value from element codes,
// compares it with the delayed input and bounds the accumulated error per window.
module ef_smsdac_chk
  import ef_smsdac_pkg::*;
#(
  parameter int unsigned LAT      = 3,
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned BOUND    = 64
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       d_in,
  input  code_t                   d_out_3,
  input  code_t                   d_out_2,
  input  code_t                   d_out_1,
  input  code_t                   d_out_0,
  output logic [DATA_W-1:0]       v_rec,
  output logic signed [ERR_W-1:0] err,
  output logic                    win_done,
  output logic                    fail,
  output logic                    bad_code,
  output logic [7:0]              fail_cnt
);

  localparam int unsigned AW = ERR_W + WIN_LOG2;
  localparam int unsigned PW = $clog2(LAT + 1);

  logic [DATA_W-1:0]       d_ref;
  logic [DATA_W-1:0]       v_c;
  logic signed [ERR_W-1:0] err_c;
  logic signed [AW-1:0]    acc_q;
  logic signed [AW-1:0]    acc_nxt;
  logic [AW-1:0]           acc_abs;
  logic [WIN_LOG2-1:0]     win_cnt_q;
  logic [PW-1:0]           prime_q;
  logic                    primed;
  logic                    qual;
  logic                    win_end;
  logic                    viol;

  ef_smsdac_dly #(
    .WIDTH (DATA_W),
    .LAT   (LAT)
  ) u_dly (
    .clk   (clk),
    .rst_b (rst_b),
    .d     (d_in),
    .q     (d_ref)
  );

  // Per-sample reconstruction, error and window-end decision.
  always_comb begin
    v_c     = recon(d_out_3, d_out_2, d_out_1, d_out_0);
    err_c   = $signed({1'b0, d_ref}) - $signed({1'b0, v_c});
    acc_nxt = acc_q + {{(AW - ERR_W){err_c[ERR_W-1]}}, err_c};
    // Unsigned magnitude: the most negative sum still fits in AW bits.
    acc_abs = acc_nxt[AW-1] ? AW'(-acc_nxt) : AW'(acc_nxt);
    viol    = 32'(acc_abs) > BOUND;
    primed  = prime_q == PW'(LAT);
    qual    = en && primed && !clr;
    win_end = qual && (&win_cnt_q);
  end

  // Reconstructed value and error, one cycle after the codes.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      v_rec <= '0;
      err   <= '0;
    end else begin
      v_rec <= v_c;
      err   <= err_c;
    end
  end

  // Priming, window accumulation and sticky status; clr wins over a window end.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      prime_q   <= '0;
      acc_q     <= '0;
      win_cnt_q <= '0;
      win_done  <= 1'b0;
      fail      <= 1'b0;
      bad_code  <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      win_done <= 1'b0;
      if (clr) begin
        prime_q   <= '0;
        acc_q     <= '0;
        win_cnt_q <= '0;
        fail      <= 1'b0;
        bad_code  <= 1'b0;
        fail_cnt  <= '0;
      end else begin
        if (!primed) begin
          prime_q <= prime_q + PW'(1);
        end
        if (qual) begin
          if (code_split(d_out_3)) begin
            bad_code <= 1'b1;
          end
          win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
          if (win_end) begin
            acc_q    <= '0;
            win_done <= 1'b1;
            if (viol) begin
              fail <= 1'b1;
              if (fail_cnt != 8'hff) begin
                fail_cnt <= fail_cnt + 8'd1;
              end
            end
          end else begin
            acc_q <= acc_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ef_smsdac_chk.sv
// Bench for ef_smsdac_chk: directed scenarios plus random traffic, all checked
// every cycle against a queue-and-integer reference model.
module tb_ef_smsdac_chk;

  localparam int LAT      = 3;
  localparam int WIN_LOG2 = 8;
  localparam int BOUND    = 64;
  localparam int WIN      = 1 << WIN_LOG2;

  logic              clk      = 1'b0;
  logic              rst_b    = 1'b0;
  logic              en       = 1'b0;
  logic              clr      = 1'b0;
  logic [7:0]        d_in     = '0;
  logic [1:0]        c3       = '0;
  logic [1:0]        c2       = '0;
  logic [1:0]        c1       = '0;
  logic [1:0]        c0       = '0;
  logic [7:0]        v_rec;
  logic signed [8:0] err;
  logic              win_done;
  logic              fail;
  logic              bad_code;
  logic [7:0]        fail_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Reference model state.
  int dly_q[$];
  int m_since, m_n, m_sum, m_v, m_err, m_fcnt;
  bit m_done, m_fail, m_bad;

  always #5 clk = ~clk;

  ef_smsdac_chk #(
    .LAT      (LAT),
    .WIN_LOG2 (WIN_LOG2),
    .BOUND    (BOUND)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (en),
    .clr      (clr),
    .d_in     (d_in),
    .d_out_3  (c3),
    .d_out_2  (c2),
    .d_out_1  (c1),
    .d_out_0  (c0),
    .v_rec    (v_rec),
    .err      (err),
    .win_done (win_done),
    .fail     (fail),
    .bad_code (bad_code),
    .fail_cnt (fail_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl(logic [1:0] c);
    return int'(c[1]) + int'(c[0]);
  endfunction

  task automatic model_reset();
    dly_q = {};
    for (int i = 0; i < LAT; i++) dly_q.push_back(0);
    m_since = 0; m_n = 0; m_sum = 0; m_v = 0; m_err = 0; m_fcnt = 0;
    m_done = 1'b0; m_fail = 1'b0; m_bad = 1'b0;
  endtask

  // Drive one cycle, advance the model, then compare every output.
  task automatic step(input bit e, input bit c, input logic [7:0] d,
                      input logic [1:0] k3, input logic [1:0] k2,
                      input logic [1:0] k1, input logic [1:0] k0);
    int d_ref;
    bit qual;
    en = e; clr = c; d_in = d; c3 = k3; c2 = k2; c1 = k1; c0 = k0;
    @(posedge clk);
    if (!rst_b) begin
      model_reset();
    end else begin
      d_ref = dly_q.pop_front();
      dly_q.push_back(int'(d));
      m_v   = 64 * lvl(k3) + 32 * lvl(k2) + 16 * lvl(k1) + 8 * lvl(k0);
      m_err = d_ref - m_v;
      qual  = e && !c && (m_since >= LAT);
      m_done = 1'b0;
      if (c) begin
        m_n = 0; m_sum = 0; m_fail = 1'b0; m_bad = 1'b0; m_fcnt = 0;
      end else if (qual) begin
        if (lvl(k3) == 1) m_bad = 1'b1;
        m_sum += m_err;
        m_n++;
        if (m_n == WIN) begin
          m_done = 1'b1;
          if ((m_sum < 0 ? -m_sum : m_sum) > BOUND) begin
            m_fail = 1'b1;
            if (m_fcnt < 255) m_fcnt++;
          end
          m_sum = 0;
          m_n   = 0;
        end
      end
      m_since = c ? 0 : m_since + 1;
    end
    #1;
    if (win_done) done_cnt++;
    check("v_rec", int'(v_rec), m_v);
    check("err", int'(err), m_err);
    check("win_done", int'(win_done), int'(m_done));
    check("fail", int'(fail), int'(m_fail));
    check("bad_code", int'(bad_code), int'(m_bad));
    check("fail_cnt", int'(fail_cnt), m_fcnt);
  endtask

  // Count cycles until win_done, optionally after a clr and with an en gap.
  task automatic run_window(input bit do_clr, input int gap_at, input int gap_len,
                            output int cycles);
    int k;
    if (do_clr) step(1'b0, 1'b1, 8'h80, 2'b11, 2'b00, 2'b00, 2'b00);
    done_cnt = 0;
    k = 0;
    while (done_cnt == 0 && k < 2 * WIN + 64) begin
      k++;
      step(!(k > gap_at && k <= gap_at + gap_len), 1'b0, 8'h80, 2'b11, 2'b00, 2'b00, 2'b00);
    end
    cycles = (done_cnt != 0) ? k : -1;
  endtask

  initial begin
    int cyc;
    model_reset();

    // Reset state.
    rst_b = 1'b0;
    repeat (3) step(1'b1, 1'b0, 8'h55, 2'b11, 2'b11, 2'b11, 2'b11);
    rst_b = 1'b1;

    // Matching data: 0x80 against 64*2 gives zero error and no failure.
    done_cnt = 0;
    repeat (LAT + WIN + 2) step(1'b1, 1'b0, 8'h80, 2'b11, 2'b00, 2'b00, 2'b00);
    check("match_done_cnt", done_cnt, 1);
    check("match_fail", int'(fail), 0);
    check("match_vrec", int'(v_rec), 128);
    check("match_err", int'(err), 0);

    // Constant +7 error: 1792 over the window exceeds the bound.
    step(1'b0, 1'b1, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    done_cnt = 0;
    repeat (LAT + WIN) step(1'b1, 1'b0, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    check("plus7_done_cnt", done_cnt, 1);
    check("plus7_fail", int'(fail), 1);
    check("plus7_fail_cnt", int'(fail_cnt), 1);
    check("plus7_err", int'(err), 7);

    // Illegal MSB code: ignored while en is low, sticky once qualified.
    step(1'b0, 1'b1, 8'h40, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (LAT) step(1'b1, 1'b0, 8'h40, 2'b01, 2'b00, 2'b00, 2'b00);
    check("bad_priming", int'(bad_code), 0);
    step(1'b0, 1'b0, 8'h40, 2'b10, 2'b00, 2'b00, 2'b00);
    check("bad_en_low", int'(bad_code), 0);
    step(1'b1, 1'b0, 8'h40, 2'b01, 2'b00, 2'b00, 2'b00);
    check("bad_set", int'(bad_code), 1);
    repeat (5) step(1'b1, 1'b0, 8'h40, 2'b11, 2'b00, 2'b00, 2'b00);
    check("bad_sticky", int'(bad_code), 1);
    step(1'b0, 1'b1, 8'h40, 2'b00, 2'b00, 2'b00, 2'b00);
    check("bad_clr", int'(bad_code), 0);

    // en gap of 10 cycles delays the window end by exactly 10.
    run_window(1'b1, 0, 0, cyc);
    check("win_time_nogap", cyc, LAT + WIN);
    run_window(1'b1, LAT + 40, 10, cyc);
    check("win_time_gap10", cyc, LAT + WIN + 10);

    // clr on the window-end sample suppresses it and restarts priming.
    step(1'b0, 1'b1, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (LAT + WIN - 1) step(1'b1, 1'b0, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    done_cnt = 0;
    step(1'b1, 1'b1, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    check("clr_end_done", done_cnt, 0);
    check("clr_end_fail", int'(fail), 0);
    run_window(1'b0, 0, 0, cyc);
    check("clr_end_restart", cyc, LAT + WIN);

    // Reset mid-window drops the partial window.
    step(1'b0, 1'b1, 8'h80, 2'b11, 2'b00, 2'b00, 2'b00);
    repeat (100) step(1'b1, 1'b0, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    done_cnt = 0;
    rst_b = 1'b0;
    repeat (2) step(1'b1, 1'b0, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    rst_b = 1'b1;
    run_window(1'b0, 0, 0, cyc);
    check("rst_mid_restart", cyc, LAT + WIN);
    check("rst_mid_fail", int'(fail), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 9) != 0), bit'($urandom_range(0, 299) == 0),
           8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    // 256 failing windows saturate the counter; reset then clears everything.
    step(1'b0, 1'b1, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    done_cnt = 0;
    repeat (LAT + 256 * WIN + 4) step(1'b1, 1'b0, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    check("sat_done_cnt", done_cnt, 256);
    check("sat_fail_cnt", int'(fail_cnt), 255);
    rst_b = 1'b0;
    repeat (2) step(1'b1, 1'b0, 8'h07, 2'b00, 2'b00, 2'b00, 2'b00);
    check("final_rst_fail_cnt", int'(fail_cnt), 0);
    check("final_rst_fail", int'(fail), 0);
    check("final_rst_vrec", int'(v_rec), 0);
    check("final_rst_err", int'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
